// File: rtl/fetch_entry_queue_if.sv
// Handshake bundle between the frontend fetch_entry producer, the queue and decode.
// The slave view is the queue itself; the master view is the frontend/decode side.
interface fetch_entry_queue_if #(
  parameter int ENTRY_W = 128
);
  logic [ENTRY_W-1:0] entry_i;
  logic               entry_valid_i;
  logic               entry_ready_o;
  logic [ENTRY_W-1:0] entry_o;
  logic               entry_valid_o;
  logic               entry_ready_i;

  modport slave (
    input  entry_i, entry_valid_i, entry_ready_i,
    output entry_ready_o, entry_o, entry_valid_o
  );

  modport master (
    output entry_i, entry_valid_i, entry_ready_i,
    input  entry_ready_o, entry_o, entry_valid_o
  );
endinterface

// File: rtl/fetch_entry_queue.sv
// Elastic FIFO between fetch and decode with flush and saturating perf counters.
// Output is first-word-fall-through from storage; there is no input-to-output bypass.
module fetch_entry_queue #(
  parameter int ENTRY_W = 128,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  fetch_entry_queue_if.slave       q_if,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         stall_cycles_o,
  output logic [CNT_W-1:0]         entries_delivered_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_next;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_deliv_cnt;
  logic               r_alive;
  logic               w_ready;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_stall;

  // Ready is held low until the first edge after reset release.
  assign w_ready = r_alive & (r_state != S_FULL) & ~flush_i;
  assign w_valid = (r_state != S_EMPTY) & ~flush_i;
  assign w_push  = q_if.entry_valid_i & w_ready;
  assign w_pop   = w_valid & q_if.entry_ready_i;
  assign w_stall = w_valid & ~q_if.entry_ready_i;

  assign q_if.entry_ready_o = w_ready;
  assign q_if.entry_valid_o = w_valid;
  assign q_if.entry_o       = r_mem[r_rd_ptr];
  assign count_o             = r_count;
  assign stall_cycles_o      = r_stall_cnt;
  assign entries_delivered_o = r_deliv_cnt;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    if (flush_i) begin
      w_state_next = S_EMPTY;
      w_count_next = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) w_state_next = S_PARTIAL;
        end
        S_PARTIAL: begin
          if (w_push && !w_pop && r_count == CW'(DEPTH - 1))
            w_state_next = S_FULL;
          else if (w_pop && !w_push && r_count == CW'(1))
            w_state_next = S_EMPTY;
        end
        S_FULL: begin
          if (w_pop) w_state_next = S_PARTIAL;
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_EMPTY;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_alive  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_alive <= 1'b1;
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage survives a flush; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= q_if.entry_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_deliv_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_pop && r_deliv_cnt != '1)   r_deliv_cnt <= r_deliv_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed bench for fetch_entry_queue: DEPTH=4 and 4-bit counters so saturation is reachable.
module tb_fetch_entry_queue;

  localparam int ENTRY_W = 128;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               flush_i = 1'b0;
  logic [2:0]         count_o;
  logic [CNT_W-1:0]   stall_cycles_o;
  logic [CNT_W-1:0]   entries_delivered_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_entry_queue_if #(.ENTRY_W(ENTRY_W)) u_if ();

  fetch_entry_queue #(
    .ENTRY_W(ENTRY_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .q_if               (u_if.slave),
    .count_o            (count_o),
    .stall_cycles_o     (stall_cycles_o),
    .entries_delivered_o(entries_delivered_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic rdy, input logic fl);
    u_if.entry_valid_i = v;
    u_if.entry_i       = d;
    u_if.entry_ready_i = rdy;
    flush_i            = fl;
    #1;
  endtask

  initial begin
    u_if.entry_valid_i = 1'b0;
    u_if.entry_i       = '0;
    u_if.entry_ready_i = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", u_if.entry_ready_o, 0);
    check("rst_valid", u_if.entry_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_entry", u_if.entry_o, 0);
    check("rst_stall", stall_cycles_o, 0);
    check("rst_deliv", entries_delivered_o, 0);
    rst_i = 1'b0;
    #1;
    check("rel_ready_pre_edge", u_if.entry_ready_o, 0);
    tick();
    check("rel_ready_post_edge", u_if.entry_ready_o, 1);

    // T1: single push, visible next cycle, drained the cycle after
    drive(1'b1, 128'hA5, 1'b1, 1'b0);
    check("t1_valid_push_cycle", u_if.entry_valid_o, 0);
    tick();
    drive(1'b0, 128'h0, 1'b1, 1'b0);
    check("t1_valid_n1", u_if.entry_valid_o, 1);
    check("t1_entry_n1", u_if.entry_o, 128'hA5);
    check("t1_count_n1", count_o, 1);
    tick();
    check("t1_count_n2", count_o, 0);
    check("t1_valid_n2", u_if.entry_valid_o, 0);
    check("t1_deliv", entries_delivered_o, 1);

    // T2: fill with decode stalled; first push cycle is not a stall
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 128'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 128'd5, 1'b0, 1'b0);
    check("t2_count_full", count_o, 4);
    check("t2_ready_full", u_if.entry_ready_o, 0);
    check("t2_stall_3", stall_cycles_o, 3);
    tick();
    check("t2_count_no_5th", count_o, 4);
    check("t2_stall_4", stall_cycles_o, 4);
    check("t2_head", u_if.entry_o, 1);

    // T3: drain from FULL with continuous input; first cycle pops without pushing
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 128'((i < 2) ? 5 : i + 4), 1'b1, 1'b0);
      check($sformatf("t3_out%0d", i), u_if.entry_o, 128'(i + 1));
      check($sformatf("t3_valid%0d", i), u_if.entry_valid_o, 1);
      check($sformatf("t3_ready%0d", i), u_if.entry_ready_o, (i != 0));
      tick();
    end
    drive(1'b0, 128'h0, 1'b0, 1'b0);
    check("t3_count", count_o, 3);
    check("t3_deliv", entries_delivered_o, 7);
    check("t3_head", u_if.entry_o, 7);

    // T4: flush at count 3 with an entry on offer
    drive(1'b1, 128'hDEAD, 1'b0, 1'b1);
    check("t4_valid_flush", u_if.entry_valid_o, 0);
    check("t4_ready_flush", u_if.entry_ready_o, 0);
    tick();
    drive(1'b0, 128'h0, 1'b0, 1'b0);
    check("t4_count_after", count_o, 0);
    check("t4_valid_after", u_if.entry_valid_o, 0);
    check("t4_ready_after", u_if.entry_ready_o, 1);
    check("t4_stall_kept", stall_cycles_o, 4);
    check("t4_deliv_kept", entries_delivered_o, 7);
    drive(1'b1, 128'h77, 1'b0, 1'b0);
    tick();
    check("t4_new_head", u_if.entry_o, 128'h77);
    drive(1'b1, 128'h88, 1'b0, 1'b0);
    tick();
    drive(1'b0, 128'h0, 1'b0, 1'b0);
    check("t5_pre_count", count_o, 2);
    check("t5_pre_stall", stall_cycles_o, 5);

    // T5: asynchronous reset mid-cycle
    rst_i = 1'b1;
    #1;
    check("t5_valid", u_if.entry_valid_o, 0);
    check("t5_count", count_o, 0);
    check("t5_stall", stall_cycles_o, 0);
    check("t5_deliv", entries_delivered_o, 0);
    check("t5_entry", u_if.entry_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // T6: stall counter saturates at 15
    drive(1'b1, 128'h3C, 1'b0, 1'b0);
    tick();
    drive(1'b0, 128'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("t6_stall_10", stall_cycles_o, 10);
    for (int i = 0; i < 10; i++) tick();
    check("t6_stall_sat", stall_cycles_o, 15);
    drive(1'b0, 128'h0, 1'b1, 1'b0);
    tick();
    check("t6_deliv", entries_delivered_o, 1);
    check("t6_stall_hold", stall_cycles_o, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
